// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared decode constants and condition evaluation for the ID stage
package id_pkg;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_EOR  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_ADC  = 4'b0101;
    localparam logic [3:0] OP_SBC  = 4'b0110;
    localparam logic [3:0] OP_TST  = 4'b1000;
    localparam logic [3:0] OP_CMP  = 4'b1010;
    localparam logic [3:0] OP_ORR  = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1101;
    localparam logic [3:0] OP_MVN  = 4'b1111;
    localparam logic [3:0] OP_LDST = 4'b0100;

    typedef enum logic [1:0] {
        MODE_DP  = 2'b00,
        MODE_MEM = 2'b01,
        MODE_BR  = 2'b10,
        MODE_UND = 2'b11
    } mode_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_e;

    // sr is {N,Z,C,V}
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] sr);
        logic n, z, c, v;
        {n, z, c, v} = sr;
        case (cond_e'(cond))
            COND_EQ: return z;
            COND_NE: return !z;
            COND_CS: return c;
            COND_CC: return !c;
            COND_MI: return n;
            COND_PL: return !n;
            COND_VS: return v;
            COND_VC: return !v;
            COND_HI: return c && !z;
            COND_LS: return !c || z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return !z && (n == v);
            COND_LE: return z || (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - IF/ID inputs, write-back port and ID/EX outputs of the decode stage
interface id_stage_if;
    logic [31:0] pc_in;
    logic [31:0] instruction_in;
    logic [3:0]  sr_in;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        two_src;
    logic [31:0] pc_out;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [3:0]  dest;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  exe_cmd;
    logic        imm;
    logic        s;
    logic        b;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en_out;

    modport master (
        output pc_in, instruction_in, sr_in, wb_en, wb_dest, wb_value,
        input  src1, src2, two_src, pc_out, val_rn, val_rm, dest, shift_operand,
               signed_imm_24, exe_cmd, imm, s, b, mem_r_en, mem_w_en, wb_en_out
    );

    modport slave (
        input  pc_in, instruction_in, sr_in, wb_en, wb_dest, wb_value,
        output src1, src2, two_src, pc_out, val_rn, val_rm, dest, shift_operand,
               signed_imm_24, exe_cmd, imm, s, b, mem_r_en, mem_w_en, wb_en_out
    );
endinterface

// File: rtl/id_stage_register_file.sv
// rtl/id_stage_register_file.sv - 16x32 register file, one write port, two write-first read ports
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [3:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_raddr1,
    input  logic [3:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2
);
    logic [31:0] r_regs [16];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_regs[i] <= '0;
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Bypass so an instruction decoded in the write-back cycle sees the new value
    assign o_rdata1 = (i_we && i_waddr == i_raddr1) ? i_wdata : r_regs[i_raddr1];
    assign o_rdata2 = (i_we && i_waddr == i_raddr2) ? i_wdata : r_regs[i_raddr2];
endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction decode, operand read and ID/EX pipeline register
module id_stage
    import id_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       freeze,
    input  logic       flush,
    id_stage_if.slave  bus
);
    logic [3:0]  w_cond, w_opcode, w_rn, w_rd, w_rm, w_src2;
    mode_e       w_mode;
    logic        w_i, w_s_bit, w_is_str;
    logic [31:0] w_val_rn, w_val_rm;
    logic [3:0]  w_exe_cmd;
    logic        w_wb, w_mr, w_mw, w_b, w_s, w_valid;

    logic [31:0] r_pc_out, r_val_rn, r_val_rm;
    logic [3:0]  r_dest, r_exe_cmd;
    logic [11:0] r_shift_operand;
    logic [23:0] r_signed_imm_24;
    logic        r_imm, r_s, r_b, r_mem_r_en, r_mem_w_en, r_wb_en_out;

    assign w_cond   = bus.instruction_in[31:28];
    assign w_mode   = mode_e'(bus.instruction_in[27:26]);
    assign w_i      = bus.instruction_in[25];
    assign w_opcode = bus.instruction_in[24:21];
    assign w_s_bit  = bus.instruction_in[20];
    assign w_rn     = bus.instruction_in[19:16];
    assign w_rd     = bus.instruction_in[15:12];
    assign w_rm     = bus.instruction_in[3:0];

    assign w_is_str    = (w_mode == MODE_MEM) && !w_s_bit;
    assign w_src2      = w_is_str ? w_rd : w_rm;
    assign bus.src1    = w_rn;
    assign bus.src2    = w_src2;
    assign bus.two_src = (!w_i && w_mode == MODE_DP) || w_is_str;

    register_file u_rf (
        .clk      (clk),
        .rst      (rst),
        .i_we     (bus.wb_en),
        .i_waddr  (bus.wb_dest),
        .i_wdata  (bus.wb_value),
        .i_raddr1 (w_rn),
        .i_raddr2 (w_src2),
        .o_rdata1 (w_val_rn),
        .o_rdata2 (w_val_rm)
    );

    always_comb begin
        w_exe_cmd = EXE_NOP;
        w_wb      = 1'b0;
        w_mr      = 1'b0;
        w_mw      = 1'b0;
        w_b       = 1'b0;
        w_s       = 1'b0;
        w_valid   = 1'b0;
        case (w_mode)
            MODE_DP: begin
                w_valid = 1'b1;
                w_wb    = 1'b1;
                w_s     = w_s_bit;
                case (w_opcode)
                    OP_MOV:  w_exe_cmd = EXE_MOV;
                    OP_MVN:  w_exe_cmd = EXE_MVN;
                    OP_ADD:  w_exe_cmd = EXE_ADD;
                    OP_ADC:  w_exe_cmd = EXE_ADC;
                    OP_SUB:  w_exe_cmd = EXE_SUB;
                    OP_SBC:  w_exe_cmd = EXE_SBC;
                    OP_AND:  w_exe_cmd = EXE_AND;
                    OP_ORR:  w_exe_cmd = EXE_ORR;
                    OP_EOR:  w_exe_cmd = EXE_EOR;
                    OP_CMP: begin w_exe_cmd = EXE_SUB; w_wb = 1'b0; end
                    OP_TST: begin w_exe_cmd = EXE_AND; w_wb = 1'b0; end
                    default: w_valid = 1'b0;
                endcase
            end
            MODE_MEM: begin
                if (w_opcode == OP_LDST) begin
                    w_valid   = 1'b1;
                    w_exe_cmd = EXE_ADD;
                    w_mr      = w_s_bit;
                    w_wb      = w_s_bit;
                    w_mw      = !w_s_bit;
                end
            end
            MODE_BR: begin
                w_valid = 1'b1;
                w_b     = 1'b1;
            end
            default: w_valid = 1'b0;
        endcase
        // Failed condition or undefined encoding: keep data fields, kill all side effects
        if (!(w_valid && cond_check(w_cond, bus.sr_in))) begin
            w_exe_cmd = EXE_NOP;
            w_wb      = 1'b0;
            w_mr      = 1'b0;
            w_mw      = 1'b0;
            w_b       = 1'b0;
            w_s       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush || freeze) begin
            r_pc_out        <= '0;
            r_val_rn        <= '0;
            r_val_rm        <= '0;
            r_dest          <= '0;
            r_shift_operand <= '0;
            r_signed_imm_24 <= '0;
            r_exe_cmd       <= '0;
            r_imm           <= 1'b0;
            r_s             <= 1'b0;
            r_b             <= 1'b0;
            r_mem_r_en      <= 1'b0;
            r_mem_w_en      <= 1'b0;
            r_wb_en_out     <= 1'b0;
        end else begin
            r_pc_out        <= bus.pc_in;
            r_val_rn        <= w_val_rn;
            r_val_rm        <= w_val_rm;
            r_dest          <= w_rd;
            r_shift_operand <= bus.instruction_in[11:0];
            r_signed_imm_24 <= bus.instruction_in[23:0];
            r_exe_cmd       <= w_exe_cmd;
            r_imm           <= w_i;
            r_s             <= w_s;
            r_b             <= w_b;
            r_mem_r_en      <= w_mr;
            r_mem_w_en      <= w_mw;
            r_wb_en_out     <= w_wb;
        end
    end

    assign bus.pc_out        = r_pc_out;
    assign bus.val_rn        = r_val_rn;
    assign bus.val_rm        = r_val_rm;
    assign bus.dest          = r_dest;
    assign bus.shift_operand = r_shift_operand;
    assign bus.signed_imm_24 = r_signed_imm_24;
    assign bus.exe_cmd       = r_exe_cmd;
    assign bus.imm           = r_imm;
    assign bus.s             = r_s;
    assign bus.b             = r_b;
    assign bus.mem_r_en      = r_mem_r_en;
    assign bus.mem_w_en      = r_mem_w_en;
    assign bus.wb_en_out     = r_wb_en_out;
endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage
module tb_id_stage;
    logic clk = 1'b0;
    logic rst, freeze, flush;

    id_stage_if bus();

    id_stage dut (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [3:0]  dest;
        logic [11:0] sh;
        logic [23:0] simm;
        logic [3:0]  cmd;
        logic        imm, s, b, mr, mw, wb;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] shadow [16];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // f = {N,Z,C,V}; odd codes are the inverse of the even code below them
    function automatic logic tb_cond(input logic [3:0] c, input logic [3:0] f);
        logic r;
        case (c[3:1])
            3'd0: r = f[2];
            3'd1: r = f[1];
            3'd2: r = f[3];
            3'd3: r = f[0];
            3'd4: r = f[1] && !f[2];
            3'd5: r = (f[3] == f[0]);
            3'd6: r = !f[2] && (f[3] == f[0]);
            default: r = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !r : r;
    endfunction

    function automatic exp_t tb_model(input logic [31:0] ins, input logic [31:0] pc, input logic [3:0] sr,
                                      input logic wbe, input logic [3:0] wbd, input logic [31:0] wbv);
        exp_t        e;
        logic [3:0]  ra;
        logic        ok;
        logic        str;
        e    = '0;
        str  = (ins[27:26] == 2'b01) && !ins[20];
        ra   = str ? ins[15:12] : ins[3:0];
        e.pc   = pc;
        e.rn   = (wbe && wbd == ins[19:16]) ? wbv : shadow[ins[19:16]];
        e.rm   = (wbe && wbd == ra) ? wbv : shadow[ra];
        e.dest = ins[15:12];
        e.sh   = ins[11:0];
        e.simm = ins[23:0];
        e.imm  = ins[25];
        ok = tb_cond(ins[31:28], sr);
        if (ok) begin
            if (ins[27:26] == 2'b00) begin
                e.s  = ins[20];
                e.wb = 1'b1;
                case (ins[24:21])
                    4'hD: e.cmd = 4'h1;
                    4'hF: e.cmd = 4'h9;
                    4'h4: e.cmd = 4'h2;
                    4'h5: e.cmd = 4'h3;
                    4'h2: e.cmd = 4'h4;
                    4'h6: e.cmd = 4'h5;
                    4'h0: e.cmd = 4'h6;
                    4'hC: e.cmd = 4'h7;
                    4'h1: e.cmd = 4'h8;
                    4'hA: begin e.cmd = 4'h4; e.wb = 1'b0; end
                    4'h8: begin e.cmd = 4'h6; e.wb = 1'b0; end
                    default: begin e.s = 1'b0; e.wb = 1'b0; end
                endcase
            end else if (ins[27:26] == 2'b01 && ins[24:21] == 4'h4) begin
                e.cmd = 4'h2;
                e.mr  = ins[20];
                e.wb  = ins[20];
                e.mw  = !ins[20];
            end else if (ins[27:26] == 2'b10) begin
                e.b = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sbq.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sbq.pop_front();
        check("pc_out", bus.pc_out, e.pc);
        check("val_rn", bus.val_rn, e.rn);
        check("val_rm", bus.val_rm, e.rm);
        check("dest", {28'd0, bus.dest}, {28'd0, e.dest});
        check("shift_op", {20'd0, bus.shift_operand}, {20'd0, e.sh});
        check("simm24", {8'd0, bus.signed_imm_24}, {8'd0, e.simm});
        check("exe_cmd", {28'd0, bus.exe_cmd}, {28'd0, e.cmd});
        check("ctl", {26'd0, bus.imm, bus.s, bus.b, bus.mem_r_en, bus.mem_w_en, bus.wb_en_out},
              {26'd0, e.imm, e.s, e.b, e.mr, e.mw, e.wb});
    endtask

    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic [3:0] sr,
                        input logic wbe, input logic [3:0] wbd, input logic [31:0] wbv,
                        input logic r, input logic fl, input logic fr);
        exp_t       e;
        logic [3:0] es2;
        logic       ets;
        @(negedge clk);
        bus.instruction_in = ins;
        bus.pc_in          = pc;
        bus.sr_in          = sr;
        bus.wb_en          = wbe;
        bus.wb_dest        = wbd;
        bus.wb_value       = wbv;
        rst    = r;
        flush  = fl;
        freeze = fr;
        e = tb_model(ins, pc, sr, wbe, wbd, wbv);
        if (r || fl || fr) e = '0;
        sbq.push_back(e);
        es2 = (ins[27:26] == 2'b01 && !ins[20]) ? ins[15:12] : ins[3:0];
        ets = (ins[27:26] == 2'b00 && !ins[25]) || (ins[27:26] == 2'b01 && !ins[20]);
        #1;
        check("src1", {28'd0, bus.src1}, {28'd0, ins[19:16]});
        check("src2", {28'd0, bus.src2}, {28'd0, es2});
        check("two_src", {31'd0, bus.two_src}, {31'd0, ets});
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 16; i++) shadow[i] = '0;
        end else if (wbe) begin
            shadow[wbd] = wbv;
        end
        #1;
        compare_out();
    endtask

    initial begin
        logic [31:0] ins;
        for (int i = 0; i < 16; i++) shadow[i] = 32'hDEAD_0000 + i;
        rst = 1'b1; flush = 1'b0; freeze = 1'b0;
        bus.instruction_in = '0; bus.pc_in = '0; bus.sr_in = '0;
        bus.wb_en = 1'b0; bus.wb_dest = '0; bus.wb_value = '0;

        step(32'h0, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(32'h0, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            ins = 32'hE080_0000 | (32'(i) << 16) | 32'(i);
            step(ins, 32'h40, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
            check("rf_zero", bus.val_rn, 32'h0);
        end

        step(32'hE1A0_0000, 32'h4, 4'h0, 1'b1, 4'd2, 32'd5, 1'b0, 1'b0, 1'b0);
        step(32'hE1A0_0000, 32'h8, 4'h0, 1'b1, 4'd3, 32'hAA, 1'b0, 1'b0, 1'b0);
        step(32'hE083_1002, 32'hC, 4'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("add_rn", bus.val_rn, 32'hAA);
        check("add_rm", bus.val_rm, 32'd5);
        check("add_cmd", {28'd0, bus.exe_cmd}, 32'h2);
        check("add_wb", {31'd0, bus.wb_en_out}, 32'd1);
        check("add_dest", {28'd0, bus.dest}, 32'd1);

        step(32'hE481_4000, 32'h10, 4'h0, 1'b1, 4'd4, 32'h1234, 1'b0, 1'b0, 1'b0);
        check("str_rm", bus.val_rm, 32'h1234);
        check("str_mw", {31'd0, bus.mem_w_en}, 32'd1);

        step(32'h0083_1002, 32'h14, 4'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("eq_fail_wb", {31'd0, bus.wb_en_out}, 32'd0);
        step(32'h0083_1002, 32'h18, 4'h4, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("eq_pass_wb", {31'd0, bus.wb_en_out}, 32'd1);

        step(32'hE491_4000, 32'h1C, 4'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("flush_mr", {31'd0, bus.mem_r_en}, 32'd0);
        check("flush_pc", bus.pc_out, 32'd0);
        step(32'hE491_4000, 32'h1C, 4'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("freeze_mr", {31'd0, bus.mem_r_en}, 32'd0);
        check("freeze_rn", bus.val_rn, 32'd0);

        step(32'hEA00_0010, 32'h100, 4'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("br_b", {31'd0, bus.b}, 32'd1);
        check("br_simm", {8'd0, bus.signed_imm_24}, 32'h10);
        check("br_wb", {31'd0, bus.wb_en_out}, 32'd0);
        check("br_pc", bus.pc_out, 32'h100);

        // Reset overrides a simultaneous write, then the register reads back as zero
        step(32'hE083_1002, 32'h20, 4'h0, 1'b1, 4'd3, 32'h55, 1'b1, 1'b0, 1'b0);
        step(32'hE083_1002, 32'h24, 4'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("rst_wr_rn", bus.val_rn, 32'h0);

        for (int k = 0; k < 80; k++) begin
            ins = $urandom;
            if ($urandom_range(0, 1) == 1) ins[31:28] = 4'hE;
            if ($urandom_range(0, 2) == 0) ins[27:26] = 2'b00;
            step(ins, $urandom, 4'($urandom), 1'($urandom), 4'($urandom), $urandom,
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage pipeline, directly downstream of the instruction-fetch stage. It takes the fetched PC and instruction, reads operands from a 16×32 register file, evaluates the condition field against the status flags, and decodes an ARM-style data-processing, memory or branch instruction into execute-stage controls. Results are captured in the ID/EX pipeline register, which the same block owns. The register file accepts one write-back per cycle from the WB stage.

## Interface
Parameters:
- none; all widths fixed. Shared constants come from `id_pkg`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `freeze`  in  1  hazard stall: loads a bubble into ID/EX.
- `flush`  in  1  branch taken (same signal as the fetch stage's `Branch_token`): loads a bubble into ID/EX.
- `pc_in`  in  32  PC+4 of the instruction from IF/ID.
- `instruction_in`  in  32  instruction from IF/ID.
- `sr_in`  in  4  status flags {N,Z,C,V}.
- `wb_en`, `wb_dest[3:0]`, `wb_value[31:0]`  in  write-back port.
- `src1`, `src2`  out  4  combinational read addresses, for the hazard unit.
- `two_src`  out  1  combinational; instruction reads a second register.
- `pc_out`, `val_rn`, `val_rm`  out  32  registered.
- `dest` 4, `shift_operand` 12, `signed_imm_24` 24, `exe_cmd` 4  out  registered.
- `imm`, `s`, `b`, `mem_r_en`, `mem_w_en`, `wb_en_out`  out  1  registered.

## Operation
- Fields: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], shift_operand[11:0], signed_imm_24[23:0].
- `src1` = Rn. `src2` = Rd when mode=01 and S=0 (STR), otherwise Rm = [3:0].
- `two_src` = (I=0 and mode=00) or STR.
- Mode 00, exe_cmd by opcode:
  - MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101.
  - AND 0000→0110, ORR 1100→0111, EOR 0001→1000.
  - CMP 1010→0100, TST 1000→0110; these two set wb_en_out=0.
  - All others set wb_en_out=1. Any other opcode is undefined.
- Mode 01, opcode 0100: exe_cmd=0010.
  - S=1 (LDR): mem_r_en=1, wb_en_out=1.
  - S=0 (STR): mem_w_en=1, wb_en_out=0.
- Mode 10: b=1, exe_cmd=0000, no write-back.
- Condition: 16 ARM codes evaluated on `sr_in`; 1110 is always true, 1111 is never true.
- A failed condition, undefined opcode, or mode 11 produces a bubble.
- Bubble: wb_en_out, mem_r_en, mem_w_en, b and s are 0, and exe_cmd=0000.
- Register file reads are write-first. If wb_en=1 and wb_dest equals the read address, the read returns wb_value in the same cycle.

## Timing
- Register file: write at posedge when wb_en=1; combinational reads.
- ID/EX latency is 1 cycle: inputs present at edge k appear on outputs after edge k.
- Priority at each posedge: rst > flush > freeze > normal load.
  - rst: all 16 registers and every ID/EX output go to 0.
  - flush or freeze: every ID/EX output goes to 0, including data fields.
  - A write-back still commits during flush/freeze. rst overrides a simultaneous write.
- Reset mid-operation discards the in-flight ID/EX contents. The first valid load occurs at the first edge after rst deasserts.
- `src1`, `src2` and `two_src` are valid in the same cycle as `instruction_in`, independent of freeze/flush.

## Structure
- `id_pkg` holds: exe_cmd encodings, opcode constants, mode constants, condition-code constants, and a condition-check function.
- Sub-module `register_file`: 16×32, synchronous reset to zero, one write port, two read ports with bypass.
- Decode logic and the ID/EX register live in `id_stage`.

## Test plan
- Reset: hold rst for 2 cycles. All outputs are 0, and reading R0–R15 returns 0.
- Write R3=0x0000_00AA at edge k, then decode ADD R1,R3,R2 (I=0) with R2=5. After the next edge: val_rn=0xAA, val_rm=5, exe_cmd=0010, wb_en_out=1, dest=1.
- Bypass: wb_en=1, wb_dest=4, wb_value=0x1234 in the same cycle as decoding STR with Rd=4. `src2`=4, `two_src`=1; after the edge val_rm=0x1234 and mem_w_en=1.
- Condition: EQ (0000) with sr_in Z=0 gives a bubble (wb_en_out=0). The same instruction with Z=1 gives wb_en_out=1.
- Flush and freeze: assert flush while decoding a valid LDR. Outputs are all zero after the edge. Repeat with freeze alone; the result is identical.
- Branch: instruction 0xEA00_0010 gives b=1, signed_imm_24=0x000010, wb_en_out=0, and pc_out equal to pc_in.
